// File: rtl/fb_pkg.sv
// Shared framebuffer types and constants: display timing, pixel record and
// the write-arbiter FSM state.
package fb_pkg;
    localparam int H_DISPLAY = 1280;
    localparam int H_FRONT   = 80;
    localparam int H_SYNC    = 136;
    localparam int H_BACK    = 216;
    localparam int V_DISPLAY = 960;
    localparam int V_FRONT   = 1;
    localparam int V_SYNC    = 3;
    localparam int V_BACK    = 30;

    localparam int X_WIDTH_DEF = $clog2(H_DISPLAY + H_FRONT + H_SYNC + H_BACK);
    localparam int Y_WIDTH_DEF = $clog2(V_DISPLAY + V_FRONT + V_SYNC + V_BACK);

    typedef struct packed {
        logic [X_WIDTH_DEF-1:0] hpos;
        logic [Y_WIDTH_DEF-1:0] vpos;
        logic [2:0]             rgb;
    } pixel_t;

    typedef enum logic {IDLE, OWN} arb_state_t;
endpackage

// File: rtl/fb_rr_picker.sv
// Rotating-priority one-hot picker: the first set request at or after ptr
// (wrapping modulo N) wins.
module fb_rr_picker #(
    parameter int N  = 3,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  win
);
    // Scan from the farthest slot back to ptr so the nearest request wins last.
    always_comb begin
        win = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) win = N'(1) << ((int'(ptr) + k) % N);
        end
    end
endmodule

// File: rtl/fb_write_arbiter.sv
// Burst round-robin arbiter sharing the framebuffer write FIFO among pixel
// sources. Define FB_ARB_PRIO0_EN to give requester 0 fixed top priority.
module fb_write_arbiter
    import fb_pkg::*;
#(
    parameter int NREQ         = 3,
    parameter int X_WIRE_WIDTH = X_WIDTH_DEF,
    parameter int Y_WIRE_WIDTH = Y_WIDTH_DEF,
    parameter int BURST_LEN    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         display_on,
    input  logic                         fifofull,
    input  logic [NREQ-1:0]              req_valid,
    input  logic [NREQ*X_WIRE_WIDTH-1:0] req_hpos,
    input  logic [NREQ*Y_WIRE_WIDTH-1:0] req_vpos,
    input  logic [NREQ*3-1:0]            req_rgb,
    output logic [NREQ-1:0]              req_ready,
    output logic [NREQ-1:0]              grant,
    output logic                         fifo_wr,
    output logic [X_WIRE_WIDTH-1:0]      hpos,
    output logic [Y_WIRE_WIDTH-1:0]      vpos,
    output logic [2:0]                   RGB
);
    localparam int PW = $clog2(NREQ);
    localparam int BW = $clog2(BURST_LEN + 1);

    arb_state_t              state, state_nxt;
    logic [NREQ-1:0]         grant_nxt, pick_req, pick_win;
    logic [PW-1:0]           rr_ptr, rr_ptr_nxt, owner;
    logic [BW-1:0]           beat_cnt, beat_nxt;
    logic                    stall, owner_valid, xfer, last_beat;
    logic [X_WIRE_WIDTH-1:0] own_h;
    logic [Y_WIRE_WIDTH-1:0] own_v;
    logic [2:0]              own_c;

    assign stall = display_on | fifofull;

    // grant is one-hot, so OR-ing the selected slices is the owner's data.
    always_comb begin
        owner = '0;
        own_h = '0;
        own_v = '0;
        own_c = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                owner = PW'(i);
                own_h = own_h | req_hpos[i*X_WIRE_WIDTH +: X_WIRE_WIDTH];
                own_v = own_v | req_vpos[i*Y_WIRE_WIDTH +: Y_WIRE_WIDTH];
                own_c = own_c | req_rgb[i*3 +: 3];
            end
        end
    end

    assign owner_valid = |(req_valid & grant);
    assign req_ready   = (state == OWN && !stall) ? grant : '0;
    assign xfer        = |(req_valid & req_ready);
    assign last_beat   = (beat_cnt == BW'(BURST_LEN - 1));

`ifdef FB_ARB_PRIO0_EN
    assign pick_req = {req_valid[NREQ-1:1], 1'b0};
`else
    assign pick_req = req_valid;
`endif

    fb_rr_picker #(.N(NREQ), .PW(PW)) u_pick (
        .req (pick_req),
        .ptr (rr_ptr),
        .win (pick_win)
    );

    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant;
        rr_ptr_nxt = rr_ptr;
        beat_nxt   = beat_cnt;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    state_nxt = OWN;
                    beat_nxt  = '0;
`ifdef FB_ARB_PRIO0_EN
                    grant_nxt = req_valid[0] ? NREQ'(1) : pick_win;
`else
                    grant_nxt = pick_win;
`endif
                end
            end
            OWN: begin
                if (!owner_valid || (xfer && last_beat)) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                    beat_nxt  = '0;
`ifdef FB_ARB_PRIO0_EN
                    // Requester 0 sits outside the rotation and leaves the pointer alone.
                    if (!grant[0])
`endif
                    rr_ptr_nxt = (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);
                end else if (xfer) begin
                    beat_nxt = beat_cnt + BW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            fifo_wr  <= 1'b0;
            hpos     <= '0;
            vpos     <= '0;
            RGB      <= '0;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            rr_ptr   <= rr_ptr_nxt;
            beat_cnt <= beat_nxt;
            fifo_wr  <= xfer;
            if (xfer) begin
                hpos <= own_h;
                vpos <= own_v;
                RGB  <= own_c;
            end
        end
    end
endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter with a per-cycle behavioural model;
// honours FB_ARB_PRIO0_EN the same way as the design.
module tb_fb_write_arbiter;
    import fb_pkg::*;
    localparam int N = 3, XW = 11, YW = 10, BL = 16;

    logic clk = 1'b0, rst = 1'b1, display_on = 1'b0, fifofull = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*XW-1:0] req_hpos = '0;
    logic [N*YW-1:0] req_vpos = '0;
    logic [N*3-1:0]  req_rgb = '0;
    logic [N-1:0]    req_ready, grant;
    logic            fifo_wr;
    logic [XW-1:0]   hpos;
    logic [YW-1:0]   vpos;
    logic [2:0]      RGB;

    always #5 clk = ~clk;

    fb_write_arbiter #(.NREQ(N), .X_WIRE_WIDTH(XW), .Y_WIRE_WIDTH(YW), .BURST_LEN(BL)) dut (
        .clk(clk), .rst(rst), .display_on(display_on), .fifofull(fifofull),
        .req_valid(req_valid), .req_hpos(req_hpos), .req_vpos(req_vpos), .req_rgb(req_rgb),
        .req_ready(req_ready), .grant(grant), .fifo_wr(fifo_wr),
        .hpos(hpos), .vpos(vpos), .RGB(RGB)
    );

    pixel_t     mem[N][64];
    int         hd[N], tl[N], popcnt[N];
    logic [N-1:0] en = '0;
    logic       rst_v = 1'b1, disp_n = 1'b0, ff_n = 1'b0;
    int         cyc = 0, n_cmp = 0, n_bad = 0;
    int         log_cyc[$];
    pixel_t     log_px[$];

    // Model: current owner (-1 = nobody), beats taken, rotation pointer, output register.
    int         m_own = -1, m_beat = 0, m_ptr = 0;
    logic       m_wr = 1'b0;
    pixel_t     m_px = '0;

    function automatic pixel_t mk(int id, int s);
        pixel_t p;
        p.hpos = XW'(id * 256 + s);
        p.vpos = YW'(id * 100 + s);
        p.rgb  = 3'(s);
        return p;
    endfunction

    task automatic push_px(int id, pixel_t p);
        mem[id][tl[id]] = p;
        tl[id]++;
    endtask

    task automatic push(int id, int s0, int n);
        for (int k = 0; k < n; k++) push_px(id, mk(id, s0 + k));
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic clear_log();
        log_cyc.delete();
        log_px.delete();
    endtask

    task automatic model_step();
        logic st;
        int w, idx;
        pixel_t p;
        st = display_on | fifofull;
        if (rst) begin
            m_own = -1; m_beat = 0; m_ptr = 0; m_wr = 1'b0; m_px = '0;
        end else if (m_own < 0) begin
            m_wr = 1'b0;
            w = -1;
`ifdef FB_ARB_PRIO0_EN
            if (req_valid[0]) w = 0;
`endif
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (w < 0 && req_valid[idx]) w = idx;
            end
            if (w >= 0) begin
                m_own = w;
                m_beat = 0;
            end
        end else begin
            m_wr = req_valid[m_own] && !st;
            if (m_wr) begin
                p.hpos = req_hpos[m_own*XW +: XW];
                p.vpos = req_vpos[m_own*YW +: YW];
                p.rgb  = req_rgb[m_own*3 +: 3];
                m_px = p;
            end
            if (!req_valid[m_own] || (m_wr && m_beat == BL - 1)) begin
`ifdef FB_ARB_PRIO0_EN
                if (m_own != 0)
`endif
                m_ptr = (m_own + 1) % N;
                m_own = -1;
                m_beat = 0;
            end else if (m_wr) begin
                m_beat++;
            end
        end
    endtask

    // One clock: drive at the falling edge, compare, then advance model and sources.
    task automatic cycle();
        logic [N-1:0] eg, er, fire;
        pixel_t p;
        @(negedge clk);
        rst = rst_v;
        display_on = disp_n;
        fifofull = ff_n;
        for (int i = 0; i < N; i++) begin
            req_valid[i] = en[i] && (hd[i] < tl[i]);
            if (hd[i] < tl[i]) begin
                req_hpos[i*XW +: XW] = mem[i][hd[i]].hpos;
                req_vpos[i*YW +: YW] = mem[i][hd[i]].vpos;
                req_rgb[i*3 +: 3]    = mem[i][hd[i]].rgb;
            end
        end
        #2;
        eg = '0;
        if (m_own >= 0) eg[m_own] = 1'b1;
        er = (display_on | fifofull) ? '0 : eg;
        chk("grant", 32'(grant), 32'(eg));
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("fifo_wr", 32'(fifo_wr), 32'(m_wr));
        chk("hpos", 32'(hpos), 32'(m_px.hpos));
        chk("vpos", 32'(vpos), 32'(m_px.vpos));
        chk("rgb", 32'(RGB), 32'(m_px.rgb));
        chk("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
        if (fifo_wr === 1'b1) begin
            p.hpos = hpos; p.vpos = vpos; p.rgb = RGB;
            log_cyc.push_back(cyc);
            log_px.push_back(p);
        end
        fire = req_valid & req_ready;
        model_step();
        for (int i = 0; i < N; i++) if (fire[i]) begin hd[i]++; popcnt[i]++; end
        cyc++;
    endtask

    task automatic wait_idle(int max);
        int n;
        bit busy;
        n = 0;
        busy = 1'b1;
        while (busy && n < max) begin
            busy = (m_own >= 0);
            for (int i = 0; i < N; i++) if (hd[i] < tl[i]) busy = 1'b1;
            if (busy) begin cycle(); n++; end
        end
        if (busy) chk("timeout_idle", 32'd1, 32'd0);
        repeat (2) cycle();
        for (int i = 0; i < N; i++) begin hd[i] = 0; tl[i] = 0; end
    endtask

    task automatic run_until_pops(int id, int target, int max);
        int n;
        n = 0;
        while (popcnt[id] < target && n < max) begin cycle(); n++; end
        if (popcnt[id] < target) chk("timeout_pops", 32'(popcnt[id]), 32'(target));
    endtask

    initial begin
        int t0, c, p0, nspec, n;
        int exp_ord[4];
        pixel_t spec;
        for (int i = 0; i < N; i++) begin hd[i] = 0; tl[i] = 0; popcnt[i] = 0; end

        // Reset state
        cycle(); cycle();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_fifo_wr", 32'(fifo_wr), 32'd0);
        rst_v = 1'b0;
        cycle();

        // All three requesters continuously valid
        clear_log();
        for (int i = 0; i < N; i++) push(i, 0, 32);
        en = 3'b111;
        wait_idle(400);
`ifdef FB_ARB_PRIO0_EN
        exp_ord = '{0, 0, 1, 2};
`else
        exp_ord = '{0, 1, 2, 0};
`endif
        chk("t2_count", 32'(log_px.size()), 32'd96);
        if (log_px.size() >= 64) begin
            for (int k = 0; k < 64; k++)
                chk("t2_order", 32'(log_px[k].hpos[10:8]), 32'(exp_ord[k/16]));
            chk("t2_gap", 32'(log_cyc[16] - log_cyc[15]), 32'd2);
        end

        // Single requester 1, 20 pixels
        clear_log();
        push(1, 0, 20);
        en = 3'b010;
        t0 = cyc;
        cycle(); cycle();
        chk("t1_grant", 32'(grant), 32'b010);
        wait_idle(100);
        chk("t1_count", 32'(log_px.size()), 32'd20);
        if (log_px.size() == 20) begin
            for (int j = 0; j < 20; j++) begin
                chk("t1_cyc", 32'(log_cyc[j]), 32'(t0 + 2 + j + (j >= 16 ? 1 : 0)));
                chk("t1_pix", 32'(log_px[j].hpos), 32'(256 + j));
            end
        end

        // display_on window after beat 5
        clear_log();
        push(0, 0, 20);
        en = 3'b001;
        p0 = popcnt[0];
        run_until_pops(0, p0 + 5, 50);
        c = cyc - 1;
        disp_n = 1'b1;
        repeat (10) cycle();
        disp_n = 1'b0;
        wait_idle(100);
        chk("t3_count", 32'(log_px.size()), 32'd20);
        if (log_px.size() == 20) begin
            chk("t3_first", 32'(log_cyc[0]), 32'(c - 3));
            chk("t3_resume", 32'(log_cyc[5]), 32'(c + 12));
            chk("t3_end", 32'(log_cyc[15]), 32'(c + 22));
            chk("t3_regrant", 32'(log_cyc[16]), 32'(c + 24));
        end

        // One-cycle fifofull pulse with a marked pixel at the head
        clear_log();
        spec.hpos = 11'h12A; spec.vpos = 10'h3C1; spec.rgb = 3'd5;
        push(2, 0, 2);
        push_px(2, spec);
        push(2, 3, 2);
        en = 3'b100;
        p0 = popcnt[2];
        run_until_pops(2, p0 + 2, 50);
        ff_n = 1'b1;
        cycle();
        ff_n = 1'b0;
        wait_idle(50);
        nspec = 0;
        foreach (log_px[k]) if (log_px[k] == spec) nspec++;
        chk("t4_spec_once", 32'(nspec), 32'd1);
        chk("t4_count", 32'(log_px.size()), 32'd5);
        if (log_px.size() == 5) begin
            chk("t4_spec_pos", 32'(log_px[2] == spec), 32'd1);
            chk("t4_skip", 32'(log_cyc[2] - log_cyc[1]), 32'd2);
        end

        // Asynchronous reset mid-burst of requester 2
        for (int i = 0; i < N; i++) push(i, 0, 20);
        en = 3'b111;
        n = 0;
        while (!(m_own == 2 && m_beat >= 3) && n < 200) begin cycle(); n++; end
        chk("t5_reached", 32'(m_own), 32'd2);
        #1 rst = 1'b1;
        rst_v = 1'b1;
        #1;
        chk("t5_rst_fifo_wr", 32'(fifo_wr), 32'd0);
        chk("t5_rst_grant", 32'(grant), 32'd0);
        chk("t5_rst_ready", 32'(req_ready), 32'd0);
        m_own = -1; m_beat = 0; m_ptr = 0; m_wr = 1'b0; m_px = '0;
        cycle();
        rst_v = 1'b0;
        cycle(); cycle();
        chk("t5_restart", 32'(grant), 32'b001);
        wait_idle(300);

        // Priority option: leave rr_ptr at 1 (round-robin build), then 0 and 1 collide
        push(0, 0, 2);
        en = 3'b001;
        wait_idle(50);
        push(0, 10, 4);
        push(1, 0, 4);
        en = 3'b011;
        cycle(); cycle();
`ifdef FB_ARB_PRIO0_EN
        chk("t6_first_grant", 32'(grant), 32'b001);
`else
        chk("t6_first_grant", 32'(grant), 32'b010);
`endif
        wait_idle(50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
        $fatal(1);
    end
endmodule
